// File: rtl/out_reg_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cnn_acc_pkg
// Shared definitions for the CNN accelerator output staging logic.
//   DEFAULT_DATA_WIDTH : default width of one result word
//   DEFAULT_NUM_SLOTS  : default number of output register slots
//   state_t            : output register controller FSM states
// ----------------------------------------------------------------------------
package cnn_acc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_NUM_SLOTS  = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/out_reg_ctrl_if.sv
// ----------------------------------------------------------------------------
// out_reg_ctrl_if
// Handshake bundle between the MAC datapath / downstream consumer and the
// output register controller.
//   In_Valid/In_Data/In_Ready    : result word offered by the MAC datapath
//   Flush                        : drain a partially filled bank
//   Out_Valid/Out_Ready/Out_Data : drained word towards the consumer
//   Out_Last                     : final word of the current drain
//   Fill_Count                   : number of occupied slots
//   Busy                         : draining, or slots occupied
// Modports: master = producer/consumer side, slave = controller side.
// ----------------------------------------------------------------------------
interface out_reg_ctrl_if
  import cnn_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_SLOTS  = DEFAULT_NUM_SLOTS
);

  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic                  OUT_REG_CTRL_In_Valid;
  logic [DATA_WIDTH-1:0] OUT_REG_CTRL_In_Data;
  logic                  OUT_REG_CTRL_In_Ready;
  logic                  OUT_REG_CTRL_Flush;
  logic                  OUT_REG_CTRL_Out_Valid;
  logic                  OUT_REG_CTRL_Out_Ready;
  logic [DATA_WIDTH-1:0] OUT_REG_CTRL_Out_Data;
  logic                  OUT_REG_CTRL_Out_Last;
  logic [CW-1:0]         OUT_REG_CTRL_Fill_Count;
  logic                  OUT_REG_CTRL_Busy;

  modport master (
    output OUT_REG_CTRL_In_Valid, OUT_REG_CTRL_In_Data, OUT_REG_CTRL_Flush,
           OUT_REG_CTRL_Out_Ready,
    input  OUT_REG_CTRL_In_Ready, OUT_REG_CTRL_Out_Valid, OUT_REG_CTRL_Out_Data,
           OUT_REG_CTRL_Out_Last, OUT_REG_CTRL_Fill_Count, OUT_REG_CTRL_Busy
  );

  modport slave (
    input  OUT_REG_CTRL_In_Valid, OUT_REG_CTRL_In_Data, OUT_REG_CTRL_Flush,
           OUT_REG_CTRL_Out_Ready,
    output OUT_REG_CTRL_In_Ready, OUT_REG_CTRL_Out_Valid, OUT_REG_CTRL_Out_Data,
           OUT_REG_CTRL_Out_Last, OUT_REG_CTRL_Fill_Count, OUT_REG_CTRL_Busy
  );

endinterface

// File: rtl/out_reg_ctrl_slot.sv
// ----------------------------------------------------------------------------
// out_reg_slot
// One output register slot: a DATA_WIDTH register with synchronous reset
// and load enable.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the stored word
//   load : capture d at the next rising edge
//   d    : word to store
//   q    : stored word
// ----------------------------------------------------------------------------
module out_reg_slot
  import cnn_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/out_reg_ctrl.sv
// ----------------------------------------------------------------------------
// out_reg_ctrl
// Collects result words from the MAC datapath into NUM_SLOTS registers and
// drains them in order to a downstream consumer, either when the bank is
// full or on a Flush request.
//   OUT_REG_CTRL_Clk   : clock, all state updates on its rising edge
//   OUT_REG_CTRL_Reset : synchronous active-high reset
//   bus                : out_reg_ctrl_if slave (input/output handshakes,
//                        Flush, Out_Last, Fill_Count, Busy)
// ----------------------------------------------------------------------------
module out_reg_ctrl
  import cnn_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_SLOTS  = DEFAULT_NUM_SLOTS
) (
  input  logic           OUT_REG_CTRL_Clk,
  input  logic           OUT_REG_CTRL_Reset,
  out_reg_ctrl_if.slave  bus
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_SLOTS);
  localparam logic [PW-1:0] LAST_PTR   = PW'(NUM_SLOTS - 1);

  state_t                state;
  state_t                state_next;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fill_count;
  logic [CW-1:0]         drain_len;
  logic                  accept;
  logic                  out_fire;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_last;
  logic [NUM_SLOTS-1:0]  set_vec;
  logic [DATA_WIDTH-1:0] slot_q [NUM_SLOTS];

  always_ff @(posedge OUT_REG_CTRL_Clk) begin
    if (OUT_REG_CTRL_Reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Reset forces all handshake outputs low, so nothing is accepted or
  // drained in a reset cycle even though the registers still hold old state.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    out_fire   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        accept   = bus.OUT_REG_CTRL_In_Valid;
        if (accept && ((fill_count + 1'b1) == FULL_COUNT)) begin
          state_next = DRAIN;
        end else if (bus.OUT_REG_CTRL_Flush && (accept || (fill_count != '0))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (CW'(rd_ptr) == (drain_len - 1'b1));
        out_fire  = bus.OUT_REG_CTRL_Out_Ready;
        if (out_fire && out_last) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
    if (OUT_REG_CTRL_Reset) begin
      accept    = 1'b0;
      out_fire  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
    end
  end

  // Pointer bookkeeping. wr_ptr saturates at the last slot so it never
  // leaves the slot range when the bank fills; the drain length latches
  // the count including any word accepted on the entry edge.
  always_ff @(posedge OUT_REG_CTRL_Clk) begin
    if (OUT_REG_CTRL_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      drain_len  <= '0;
    end else begin
      if (accept) begin
        fill_count <= fill_count + 1'b1;
        if (wr_ptr != LAST_PTR) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if ((state == FILL) && (state_next == DRAIN)) begin
        drain_len <= fill_count + CW'(accept);
      end
      if (out_fire) begin
        if (out_last) begin
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          fill_count <= '0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // One-hot load enable for the slot addressed by wr_ptr.
  always_comb begin
    set_vec = '0;
    if (accept) begin
      set_vec[wr_ptr] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    out_reg_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk  (OUT_REG_CTRL_Clk),
      .rst  (OUT_REG_CTRL_Reset),
      .load (set_vec[i]),
      .d    (bus.OUT_REG_CTRL_In_Data),
      .q    (slot_q[i])
    );
  end

  assign bus.OUT_REG_CTRL_In_Ready   = in_ready;
  assign bus.OUT_REG_CTRL_Out_Valid  = out_valid;
  assign bus.OUT_REG_CTRL_Out_Last   = out_last;
  assign bus.OUT_REG_CTRL_Out_Data   = OUT_REG_CTRL_Reset ? '0 : slot_q[rd_ptr];
  assign bus.OUT_REG_CTRL_Fill_Count = fill_count;
  assign bus.OUT_REG_CTRL_Busy       = !OUT_REG_CTRL_Reset &&
                                       ((state == DRAIN) || (fill_count != '0));

endmodule

// File: tb/tb_out_reg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_out_reg_ctrl
// Directed self-checking bench for out_reg_ctrl (DATA_WIDTH=16, NUM_SLOTS=4).
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_out_reg_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  out_reg_ctrl_if #(.DATA_WIDTH(16), .NUM_SLOTS(4)) bus ();

  out_reg_ctrl #(
    .DATA_WIDTH(16),
    .NUM_SLOTS (4)
  ) dut (
    .OUT_REG_CTRL_Clk   (clk),
    .OUT_REG_CTRL_Reset (rst),
    .bus                (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: time=%0t required=finish", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.OUT_REG_CTRL_In_Valid  = 1'b0;
    bus.OUT_REG_CTRL_In_Data   = 16'd0;
    bus.OUT_REG_CTRL_Flush     = 1'b0;
    bus.OUT_REG_CTRL_Out_Ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_In_Ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", bus.OUT_REG_CTRL_In_Ready);
    end
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_Out_Last !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out valid=%b last=%b exp=0/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Out_Last);
    end
    checks++;
    if (bus.OUT_REG_CTRL_Busy !== 1'b0 || bus.OUT_REG_CTRL_Out_Data !== 16'd0 ||
        bus.OUT_REG_CTRL_Fill_Count !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_state busy=%b data=%0d fill=%0d exp=0/0/0",
                         bus.OUT_REG_CTRL_Busy, bus.OUT_REG_CTRL_Out_Data,
                         bus.OUT_REG_CTRL_Fill_Count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_In_Ready !== 1'b1 || bus.OUT_REG_CTRL_Out_Valid !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset in_ready=%b out_valid=%b exp=1/0",
                         bus.OUT_REG_CTRL_In_Ready, bus.OUT_REG_CTRL_Out_Valid);
    end
  endtask

  task automatic test_full_drain();
    bus.OUT_REG_CTRL_Out_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.OUT_REG_CTRL_In_Valid = 1'b1;
      bus.OUT_REG_CTRL_In_Data  = 16'(k + 1);
      checks++;
      if (bus.OUT_REG_CTRL_Fill_Count !== 3'(k) || bus.OUT_REG_CTRL_Out_Valid !== 1'b0 ||
          bus.OUT_REG_CTRL_In_Ready !== 1'b1) begin
        errors++; $display("[TB] FAIL full_fill%0d fill=%0d valid=%b ready=%b exp=%0d/0/1", k,
                           bus.OUT_REG_CTRL_Fill_Count, bus.OUT_REG_CTRL_Out_Valid,
                           bus.OUT_REG_CTRL_In_Ready, k);
      end
      @(negedge clk);
    end
    bus.OUT_REG_CTRL_In_Valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.OUT_REG_CTRL_Out_Valid !== 1'b1 || bus.OUT_REG_CTRL_Out_Data !== 16'(k + 1) ||
          bus.OUT_REG_CTRL_Out_Last !== (k == 3) || bus.OUT_REG_CTRL_In_Ready !== 1'b0) begin
        errors++; $display("[TB] FAIL full_drain%0d valid=%b data=%0d last=%b ready=%b exp=1/%0d/%b/0",
                           k, bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Out_Data,
                           bus.OUT_REG_CTRL_Out_Last, bus.OUT_REG_CTRL_In_Ready, k + 1, (k == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_In_Ready !== 1'b1 ||
        bus.OUT_REG_CTRL_Fill_Count !== 3'd0 || bus.OUT_REG_CTRL_Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL full_return valid=%b ready=%b fill=%0d busy=%b exp=0/1/0/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_In_Ready,
                         bus.OUT_REG_CTRL_Fill_Count, bus.OUT_REG_CTRL_Busy);
    end
  endtask

  task automatic test_flush();
    bus.OUT_REG_CTRL_Out_Ready = 1'b0;
    bus.OUT_REG_CTRL_In_Valid  = 1'b1;
    bus.OUT_REG_CTRL_In_Data   = 16'd10;
    @(negedge clk);
    bus.OUT_REG_CTRL_In_Data   = 16'd20;
    @(negedge clk);
    bus.OUT_REG_CTRL_In_Valid  = 1'b0;
    bus.OUT_REG_CTRL_Flush     = 1'b1;
    checks++;
    if (bus.OUT_REG_CTRL_Fill_Count !== 3'd2 || bus.OUT_REG_CTRL_Busy !== 1'b1 ||
        bus.OUT_REG_CTRL_Out_Valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_pre fill=%0d busy=%b valid=%b exp=2/1/0",
                         bus.OUT_REG_CTRL_Fill_Count, bus.OUT_REG_CTRL_Busy,
                         bus.OUT_REG_CTRL_Out_Valid);
    end
    @(negedge clk);
    bus.OUT_REG_CTRL_Out_Ready = 1'b1;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b1 || bus.OUT_REG_CTRL_Out_Data !== 16'd10 ||
        bus.OUT_REG_CTRL_Out_Last !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_w0 valid=%b data=%0d last=%b exp=1/10/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Out_Data,
                         bus.OUT_REG_CTRL_Out_Last);
    end
    @(negedge clk);
    bus.OUT_REG_CTRL_Flush = 1'b0;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b1 || bus.OUT_REG_CTRL_Out_Data !== 16'd20 ||
        bus.OUT_REG_CTRL_Out_Last !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_w1 valid=%b data=%0d last=%b exp=1/20/1",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Out_Data,
                         bus.OUT_REG_CTRL_Out_Last);
    end
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_In_Ready !== 1'b1 ||
        bus.OUT_REG_CTRL_Fill_Count !== 3'd0) begin
      errors++; $display("[TB] FAIL flush_return valid=%b ready=%b fill=%0d exp=0/1/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_In_Ready,
                         bus.OUT_REG_CTRL_Fill_Count);
    end
  endtask

  task automatic test_flush_with_accept();
    bus.OUT_REG_CTRL_Out_Ready = 1'b1;
    bus.OUT_REG_CTRL_In_Valid  = 1'b1;
    bus.OUT_REG_CTRL_In_Data   = 16'd5;
    @(negedge clk);
    bus.OUT_REG_CTRL_In_Data   = 16'd7;
    bus.OUT_REG_CTRL_Flush     = 1'b1;
    checks++;
    if (bus.OUT_REG_CTRL_Fill_Count !== 3'd1 || bus.OUT_REG_CTRL_Out_Valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flacc_pre fill=%0d valid=%b exp=1/0",
                         bus.OUT_REG_CTRL_Fill_Count, bus.OUT_REG_CTRL_Out_Valid);
    end
    @(negedge clk);
    bus.OUT_REG_CTRL_In_Valid = 1'b0;
    bus.OUT_REG_CTRL_Flush    = 1'b0;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b1 || bus.OUT_REG_CTRL_Out_Data !== 16'd5 ||
        bus.OUT_REG_CTRL_Out_Last !== 1'b0) begin
      errors++; $display("[TB] FAIL flacc_w0 valid=%b data=%0d last=%b exp=1/5/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Out_Data,
                         bus.OUT_REG_CTRL_Out_Last);
    end
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b1 || bus.OUT_REG_CTRL_Out_Data !== 16'd7 ||
        bus.OUT_REG_CTRL_Out_Last !== 1'b1) begin
      errors++; $display("[TB] FAIL flacc_w1 valid=%b data=%0d last=%b exp=1/7/1",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Out_Data,
                         bus.OUT_REG_CTRL_Out_Last);
    end
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_In_Ready !== 1'b1 || bus.OUT_REG_CTRL_Fill_Count !== 3'd0) begin
      errors++; $display("[TB] FAIL flacc_return ready=%b fill=%0d exp=1/0",
                         bus.OUT_REG_CTRL_In_Ready, bus.OUT_REG_CTRL_Fill_Count);
    end
  endtask

  task automatic test_backpressure();
    bus.OUT_REG_CTRL_Out_Ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.OUT_REG_CTRL_In_Valid = 1'b1;
      bus.OUT_REG_CTRL_In_Data  = 16'(11 + k);
      @(negedge clk);
    end
    bus.OUT_REG_CTRL_In_Data   = 16'd99;
    bus.OUT_REG_CTRL_Out_Ready = 1'b1;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Data !== 16'd11 || bus.OUT_REG_CTRL_Out_Valid !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_w0 data=%0d valid=%b exp=11/1",
                         bus.OUT_REG_CTRL_Out_Data, bus.OUT_REG_CTRL_Out_Valid);
    end
    @(negedge clk);
    bus.OUT_REG_CTRL_Out_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.OUT_REG_CTRL_Out_Data !== 16'd12 || bus.OUT_REG_CTRL_Out_Last !== 1'b0 ||
          bus.OUT_REG_CTRL_In_Ready !== 1'b0 || bus.OUT_REG_CTRL_Fill_Count !== 3'd4 ||
          bus.OUT_REG_CTRL_Out_Valid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_hold%0d data=%0d last=%b ready=%b fill=%0d valid=%b exp=12/0/0/4/1",
                           k, bus.OUT_REG_CTRL_Out_Data, bus.OUT_REG_CTRL_Out_Last,
                           bus.OUT_REG_CTRL_In_Ready, bus.OUT_REG_CTRL_Fill_Count,
                           bus.OUT_REG_CTRL_Out_Valid);
      end
      @(negedge clk);
    end
    bus.OUT_REG_CTRL_In_Valid  = 1'b0;
    bus.OUT_REG_CTRL_Out_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.OUT_REG_CTRL_Out_Data !== 16'(12 + k) || bus.OUT_REG_CTRL_Out_Last !== (k == 2)) begin
        errors++; $display("[TB] FAIL bp_drain%0d data=%0d last=%b exp=%0d/%b", k,
                           bus.OUT_REG_CTRL_Out_Data, bus.OUT_REG_CTRL_Out_Last, 12 + k, (k == 2));
      end
      @(negedge clk);
    end
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_Fill_Count !== 3'd0 ||
        bus.OUT_REG_CTRL_In_Ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_return valid=%b fill=%0d ready=%b exp=0/0/1",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Fill_Count,
                         bus.OUT_REG_CTRL_In_Ready);
    end
  endtask

  task automatic test_empty_flush();
    bus.OUT_REG_CTRL_Flush = 1'b1;
    @(negedge clk);
    bus.OUT_REG_CTRL_Flush = 1'b0;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_Busy !== 1'b0 ||
        bus.OUT_REG_CTRL_In_Ready !== 1'b1 || bus.OUT_REG_CTRL_Fill_Count !== 3'd0) begin
      errors++; $display("[TB] FAIL empty_flush valid=%b busy=%b ready=%b fill=%0d exp=0/0/1/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Busy,
                         bus.OUT_REG_CTRL_In_Ready, bus.OUT_REG_CTRL_Fill_Count);
    end
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0) begin
      errors++; $display("[TB] FAIL empty_flush_late valid=%b exp=0", bus.OUT_REG_CTRL_Out_Valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    bus.OUT_REG_CTRL_Out_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.OUT_REG_CTRL_In_Valid = 1'b1;
      bus.OUT_REG_CTRL_In_Data  = 16'(21 + k);
      @(negedge clk);
    end
    bus.OUT_REG_CTRL_In_Valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_Out_Data !== 16'd22 || bus.OUT_REG_CTRL_Out_Valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_mid_pre data=%0d valid=%b exp=22/1",
                         bus.OUT_REG_CTRL_Out_Data, bus.OUT_REG_CTRL_Out_Valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_In_Ready !== 1'b0 ||
        bus.OUT_REG_CTRL_Out_Data !== 16'd0) begin
      errors++; $display("[TB] FAIL rst_mid_during valid=%b ready=%b data=%0d exp=0/0/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_In_Ready,
                         bus.OUT_REG_CTRL_Out_Data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_Fill_Count !== 3'd0 ||
        bus.OUT_REG_CTRL_In_Ready !== 1'b1 || bus.OUT_REG_CTRL_Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_after valid=%b fill=%0d ready=%b busy=%b exp=0/0/1/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Fill_Count,
                         bus.OUT_REG_CTRL_In_Ready, bus.OUT_REG_CTRL_Busy);
    end
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_late valid=%b exp=0", bus.OUT_REG_CTRL_Out_Valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.OUT_REG_CTRL_Out_Ready = 1'b1;
    bus.OUT_REG_CTRL_In_Valid  = 1'b1;
    bus.OUT_REG_CTRL_In_Data   = 16'd33;
    bus.OUT_REG_CTRL_Flush     = 1'b1;
    @(negedge clk);
    bus.OUT_REG_CTRL_In_Valid  = 1'b0;
    bus.OUT_REG_CTRL_Flush     = 1'b0;
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b1 || bus.OUT_REG_CTRL_Out_Data !== 16'd33 ||
        bus.OUT_REG_CTRL_Out_Last !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_single valid=%b data=%0d last=%b exp=1/33/1",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_Out_Data,
                         bus.OUT_REG_CTRL_Out_Last);
    end
    @(negedge clk);
    checks++;
    if (bus.OUT_REG_CTRL_Out_Valid !== 1'b0 || bus.OUT_REG_CTRL_In_Ready !== 1'b1 ||
        bus.OUT_REG_CTRL_Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_return valid=%b ready=%b busy=%b exp=0/1/0",
                         bus.OUT_REG_CTRL_Out_Valid, bus.OUT_REG_CTRL_In_Ready,
                         bus.OUT_REG_CTRL_Busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_drain();
    test_flush();
    test_flush_with_accept();
    test_backpressure();
    test_empty_flush();
    test_reset_mid_drain();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_reg_ctrl.md
OUT_REG_CTRL -- requirements
Module: out_reg_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the width of one result word.
REQ-002 The block SHALL have parameter NUM_SLOTS, default 4, the number of output register slots (legal range 2..16).
REQ-003 The block SHALL have port OUT_REG_CTRL_Clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port OUT_REG_CTRL_Reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port OUT_REG_CTRL_In_Valid, input, 1, indicating a result word is offered on In_Data.
REQ-006 The block SHALL have port OUT_REG_CTRL_In_Data, input, DATA_WIDTH, carrying the result word from the MAC datapath.
REQ-007 The block SHALL have port OUT_REG_CTRL_In_Ready, output, 1, indicating the block accepts a word this cycle.
REQ-008 The block SHALL have port OUT_REG_CTRL_Flush, input, 1, a request to drain a partially filled bank.
REQ-009 The block SHALL have port OUT_REG_CTRL_Out_Valid, output, 1, indicating Out_Data holds a valid drained word.
REQ-010 The block SHALL have port OUT_REG_CTRL_Out_Ready, input, 1, indicating the downstream consumer accepts the word.
REQ-011 The block SHALL have port OUT_REG_CTRL_Out_Data, output, DATA_WIDTH, carrying the drained word.
REQ-012 The block SHALL have port OUT_REG_CTRL_Out_Last, output, 1, marking the final word of the current drain.
REQ-013 The block SHALL have port OUT_REG_CTRL_Fill_Count, output, clog2(NUM_SLOTS+1), giving the number of occupied slots.
REQ-014 The block SHALL have port OUT_REG_CTRL_Busy, output, 1, high when the state is DRAIN or Fill_Count is nonzero.

Function
REQ-015 The block SHALL implement a two-state FSM, FILL and DRAIN.
REQ-016 In FILL, In_Ready SHALL be 1 and Out_Valid SHALL be 0.
REQ-017 In FILL, In_Valid && In_Ready SHALL write In_Data into slot[wr_ptr] at the clock edge and increment both wr_ptr and Fill_Count.
REQ-018 When an accept brings Fill_Count to NUM_SLOTS, the FSM SHALL enter DRAIN at that edge, with drain length equal to NUM_SLOTS.
REQ-019 In FILL, Flush with Fill_Count>0, or with an accept in the same cycle, SHALL enter DRAIN with drain length equal to Fill_Count plus that accept, where the same-cycle word is included.
REQ-020 In FILL, Flush with Fill_Count==0 and no accept SHALL be ignored, with no state change.
REQ-021 In DRAIN, In_Ready SHALL be 0, Out_Valid SHALL be 1, and Out_Data SHALL equal slot[rd_ptr], with rd_ptr starting at 0.
REQ-022 In DRAIN, Out_Valid && Out_Ready SHALL increment rd_ptr.
REQ-023 Out_Last SHALL be 1 exactly when rd_ptr == drain length-1 during DRAIN.
REQ-024 While Out_Valid=1 and Out_Ready=0, Out_Data and Out_Last SHALL remain stable.
REQ-025 The handshake on the last word SHALL return the FSM to FILL and clear wr_ptr, rd_ptr and Fill_Count, so that In_Ready=1 in the next cycle.
REQ-026 Flush asserted in DRAIN SHALL be ignored.
REQ-027 In_Valid asserted in DRAIN SHALL not be accepted; the producer holds the word.
REQ-028 The latency from the edge that accepts the filling or flushed word to Out_Valid=1 SHALL be 1 cycle.
REQ-029 With Out_Ready held at 1, a drain of L words SHALL complete in L cycles.
REQ-030 Pointers SHALL never exceed NUM_SLOTS-1, with no wrap-around inside a drain.

Reset
REQ-031 While Reset=1 at a clock edge, the block SHALL set the state to FILL, clear wr_ptr, rd_ptr, Fill_Count and all slots to 0, and force In_Ready=0, Out_Valid=0, Out_Last=0, Busy=0 and Out_Data=0.
REQ-032 A reset asserted mid-fill or mid-drain SHALL discard all stored words, and no further Out_Valid SHALL occur for them.
REQ-033 In the first cycle after Reset deasserts, In_Ready SHALL be 1.

Structure
REQ-034 The FSM state encoding and the DATA_WIDTH and NUM_SLOTS defaults SHALL reside in a shared package (cnn_acc_pkg).
REQ-035 Each slot SHALL be an instance of the sub-module out_reg_slot, a DATA_WIDTH register with clock, sync reset and load enable, driven by a one-hot set vector decoded from wr_ptr.
REQ-036 Out_Data SHALL be a multiplexer over the slot outputs selected by rd_ptr.

Verification
REQ-037 The bench SHALL apply 4 back-to-back accepts of 1,2,3,4 with Out_Ready=1 and check that Out_Valid rises the next cycle, Out_Data is 1,2,3,4 on consecutive cycles, and Out_Last=1 only with 4.
REQ-038 The bench SHALL accept 10 and 20, then apply Flush, and check a drain of exactly 2 words (10, 20) with Out_Last on 20 and a return to FILL.
REQ-039 The bench SHALL apply Flush together with an accept of 7 when Fill_Count=1 (slot0=5), and check a drain of 5 then 7, with Out_Last on 7.
REQ-040 The bench SHALL hold Out_Ready=0 for 3 cycles during a drain and check that Out_Data stays at the current word, In_Ready stays 0, and In_Valid=1 is not accepted.
REQ-041 The bench SHALL apply Flush with Fill_Count=0 and check that the state stays FILL, Out_Valid=0 and Busy=0.
REQ-042 The bench SHALL assert Reset for one cycle at rd_ptr=1 of a 4-word drain and check Out_Valid=0, Fill_Count=0 and In_Ready=1 in the cycle after release.
